// File: rtl/z80_index_arith_pkg.sv
// Shared types and defaults for the Z80 index-register arithmetic unit.
package z80_index_arith_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_SLICE    = 4;
  localparam int DEF_NUM_REGS = 2;

  typedef enum logic [1:0] {
    OP_INC  = 2'b00,
    OP_DEC  = 2'b01,
    OP_ADDD = 2'b10,
    OP_RSVD = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic logic sel_in_range(input int sel, input int num_regs);
    return sel < num_regs;
  endfunction

endpackage

// File: rtl/z80_slice_adder.sv
// Combinational W-bit adder slice with carry in and carry out.
module z80_slice_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};

endmodule

// File: rtl/z80_index_arith_unit.sv
// Multi-cycle index-register INC/DEC/displacement-add unit; one narrow slice
// adder is stepped across the word, LSB slice first.
module z80_index_arith_unit
  import z80_index_arith_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int SLICE    = DEF_SLICE,
  parameter int NUM_REGS = DEF_NUM_REGS,
  localparam int SEL_W   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_op,
  input  logic [SEL_W-1:0]          req_sel,
  input  logic [7:0]                req_disp,
  input  logic [15:0]               req_ip,
  input  logic [2:0]                req_len,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [WIDTH-1:0]          rsp_result,
  output logic                      rsp_carry,
  output logic [15:0]               rsp_ip,
  input  logic                      ld_valid,
  input  logic [SEL_W-1:0]          ld_sel,
  input  logic [WIDTH-1:0]          ld_data,
  output logic [NUM_REGS*WIDTH-1:0] regs_out
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  if ((WIDTH % SLICE) != 0) begin : g_bad_slice
    $error("z80_index_arith_unit: SLICE must divide WIDTH exactly");
  end

  state_t               state_reg;
  op_t                  op_reg;
  logic [SEL_W-1:0]     sel_reg;
  logic [WIDTH-1:0]     a_reg;
  logic [WIDTH-1:0]     b_reg;
  logic [WIDTH-1:0]     result_reg;
  logic                 carry_reg;
  logic [15:0]          ip_reg;
  logic [CNT_W-1:0]     cnt_reg;
  logic                 rsp_valid_reg;
  logic [WIDTH-1:0]     regs_reg [NUM_REGS];

  logic [WIDTH-1:0]     a_next;
  logic [WIDTH-1:0]     b_next;
  logic [SLICE-1:0]     slice_sum;
  logic                 slice_cout;

  always_comb begin
    a_next = '0;
    if (sel_in_range(int'(req_sel), NUM_REGS)) a_next = regs_reg[req_sel];
    case (op_t'(req_op))
      OP_INC:  b_next = WIDTH'(1);
      OP_DEC:  b_next = '1;
      OP_ADDD: b_next = {{(WIDTH-8){req_disp[7]}}, req_disp};
      default: b_next = '0;
    endcase
  end

  z80_slice_adder #(.W(SLICE)) u_slice_adder (
    .a    (a_reg[cnt_reg*SLICE +: SLICE]),
    .b    (b_reg[cnt_reg*SLICE +: SLICE]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= ST_IDLE;
      op_reg        <= OP_INC;
      sel_reg       <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      result_reg    <= '0;
      carry_reg     <= 1'b0;
      ip_reg        <= '0;
      cnt_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_reg[i] <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            a_reg     <= a_next;
            b_reg     <= b_next;
            op_reg    <= op_t'(req_op);
            sel_reg   <= req_sel;
            ip_reg    <= req_ip + 16'(req_len);
            cnt_reg   <= '0;
            carry_reg <= 1'b0;
            state_reg <= ST_CALC;
          end else if (ld_valid && sel_in_range(int'(ld_sel), NUM_REGS)) begin
            regs_reg[ld_sel] <= ld_data;
          end
        end
        ST_CALC: begin
          result_reg[cnt_reg*SLICE +: SLICE] <= slice_sum;
          carry_reg <= slice_cout;
          if (cnt_reg == CNT_W'(NSLICE - 1)) begin
            state_reg     <= ST_DONE;
            rsp_valid_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_ready) begin
            rsp_valid_reg <= 1'b0;
            state_reg     <= ST_IDLE;
            // Address generation (ADDD) never modifies the index register.
            if ((op_reg == OP_INC || op_reg == OP_DEC) &&
                sel_in_range(int'(sel_reg), NUM_REGS))
              regs_reg[sel_reg] <= result_reg;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign req_ready  = (state_reg == ST_IDLE);
  assign rsp_valid  = rsp_valid_reg;
  assign rsp_result = result_reg;
  assign rsp_carry  = carry_reg;
  assign rsp_ip     = ip_reg;

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
    assign regs_out[gi*WIDTH +: WIDTH] = regs_reg[gi];
  end

endmodule

// File: tb/tb_z80_index_arith_unit.sv
// Directed self-checking bench for z80_index_arith_unit (default parameters).
module tb_z80_index_arith_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_op;
  logic [0:0]  req_sel;
  logic [7:0]  req_disp;
  logic [15:0] req_ip;
  logic [2:0]  req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic        rsp_carry;
  logic [15:0] rsp_ip;
  logic        ld_valid;
  logic [0:0]  ld_sel;
  logic [15:0] ld_data;
  logic [31:0] regs_out;

  int vectors = 0;
  int miscompares = 0;

  z80_index_arith_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_sel    (req_sel),
    .req_disp   (req_disp),
    .req_ip     (req_ip),
    .req_len    (req_len),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_carry  (rsp_carry),
    .rsp_ip     (rsp_ip),
    .ld_valid   (ld_valid),
    .ld_sel     (ld_sel),
    .ld_data    (ld_data),
    .regs_out   (regs_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic sel, input logic [15:0] data);
    ld_valid = 1'b1;
    ld_sel   = sel;
    ld_data  = data;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
  endtask

  // Issue a request and wait for rsp_valid, checking latency and response.
  task automatic issue(input string tag, input logic [1:0] op, input logic sel,
                       input logic [7:0] disp, input logic [15:0] ip, input logic [2:0] len,
                       input logic [15:0] exp_res, input logic exp_c, input logic [15:0] exp_ip);
    int cyc;
    req_valid = 1'b1;
    req_op    = op;
    req_sel   = sel;
    req_disp  = disp;
    req_ip    = ip;
    req_len   = len;
    @(negedge clk);
    req_valid = 1'b0;
    req_disp  = 8'h5A;
    req_ip    = 16'hDEAD;
    cyc = 1;
    check({tag, " req_ready in CALC"}, 32'(req_ready), 32'd0);
    while (!rsp_valid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, 32'(cyc), 32'd5);
    $display("%s: op=%0d sel=%0d result=%h carry=%0d ip=%h", tag, op, sel, rsp_result, rsp_carry, rsp_ip);
    check({tag, " result"}, 32'(rsp_result), 32'(exp_res));
    check({tag, " carry"}, 32'(rsp_carry), 32'(exp_c));
    check({tag, " ip"}, 32'(rsp_ip), 32'(exp_ip));
  endtask

  task automatic handshake();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    reset_n   = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_sel   = 1'b0;
    req_disp  = 8'h00;
    req_ip    = 16'h0000;
    req_len   = 3'd0;
    rsp_ready = 1'b0;
    ld_valid  = 1'b0;
    ld_sel    = 1'b0;
    ld_data   = 16'h0000;
    repeat (2) @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset regs", regs_out, 32'h0000_0000);
    check("reset result", 32'(rsp_result), 32'd0);
    check("reset carry", 32'(rsp_carry), 32'd0);
    check("reset ip", 32'(rsp_ip), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // INC IX
    do_load(1'b0, 16'h12FF);
    check("load reg0", regs_out, 32'h0000_12FF);
    issue("inc_ix", 2'b00, 1'b0, 8'h00, 16'h0100, 3'd2, 16'h1300, 1'b0, 16'h0102);
    check("inc_ix no early wb", regs_out, 32'h0000_12FF);
    handshake();
    check("inc_ix wb", regs_out, 32'h0000_1300);
    check("inc_ix req_ready", 32'(req_ready), 32'd1);

    // DEC IY wrapping through zero
    do_load(1'b1, 16'h0000);
    issue("dec_iy", 2'b01, 1'b1, 8'h00, 16'h0200, 3'd2, 16'hFFFF, 1'b0, 16'h0202);
    handshake();
    check("dec_iy wb", regs_out, 32'hFFFF_1300);

    // ADDD negative displacement with IP wrap; no writeback
    do_load(1'b0, 16'h8000);
    issue("addd_neg", 2'b10, 1'b0, 8'h80, 16'hFFFF, 3'd2, 16'h7F80, 1'b1, 16'h0001);
    handshake();
    check("addd_neg no wb", regs_out, 32'hFFFF_8000);

    // Load coincident with a request is dropped; INC of all ones under backpressure
    ld_valid = 1'b1;
    ld_sel   = 1'b0;
    ld_data  = 16'hAAAA;
    issue("inc_wrap", 2'b00, 1'b1, 8'h00, 16'h0010, 3'd3, 16'h0000, 1'b1, 16'h0013);
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1;
      ld_sel   = 1'b0;
      ld_data  = 16'h1234;
      @(negedge clk);
      ld_valid = 1'b0;
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp req_ready", 32'(req_ready), 32'd0);
      check("bp result", 32'(rsp_result), 32'h0000);
      check("bp carry", 32'(rsp_carry), 32'd1);
      check("bp ip", 32'(rsp_ip), 32'h0013);
      check("bp regs", regs_out, 32'hFFFF_8000);
    end
    handshake();
    check("inc_wrap wb", regs_out, 32'h0000_8000);
    check("inc_wrap rsp_valid low", 32'(rsp_valid), 32'd0);

    // Reset in the middle of CALC
    do_load(1'b0, 16'h0005);
    req_valid = 1'b1;
    req_op    = 2'b00;
    req_sel   = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("midrst regs", regs_out, 32'h0000_0000);
    check("midrst rsp_valid", 32'(rsp_valid), 32'd0);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    repeat (6) @(negedge clk);
    check("midrst still idle", 32'(rsp_valid), 32'd0);
    check("midrst no wb", regs_out, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/z80_index_arith_unit.md
Name: z80_index_arith_unit

Overview:
Multi-cycle 16-bit index-register arithmetic unit for the core's IX/IY-class registers.
- Owns a small bank of index registers and executes INC, DEC and displacement-add (IX+d address generation) on them.
- Uses a narrow slice adder iterated over the word, as the Z80's 4-bit ALU does.
- Also produces the updated instruction pointer, so the z80fi spec for INC/DEC IX/IY and (IX+d) addressing can be checked against it.

Parameters:
- WIDTH, 16: index register and result width in bits.
- SLICE, 4: adder slice width in bits; must divide WIDTH exactly (elaboration error otherwise).
- NUM_REGS, 2: number of index registers (0 = IX, 1 = IY, 2+ = extension).

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  operation request.
- req_ready  out  1  unit idle, can accept a request.
- req_op  in  2  operation code: 00 INC, 01 DEC, 10 ADDD, 11 reserved.
- req_sel  in  max(1,$clog2(NUM_REGS))  register select.
- req_disp  in  8  signed displacement, used by ADDD.
- req_ip  in  16  instruction pointer at the instruction start.
- req_len  in  3  instruction length in bytes.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_result  out  WIDTH  arithmetic result.
- rsp_carry  out  1  carry out of the MSB slice.
- rsp_ip  out  16  (req_ip + req_len) mod 2^16.
- ld_valid  in  1  direct register load.
- ld_sel  in  same as req_sel  load target.
- ld_data  in  WIDTH  load value.
- regs_out  out  NUM_REGS*WIDTH  flattened register bank; reg k occupies bits [k*WIDTH +: WIDTH].

Behaviour:
- Async reset (reset_n low): all registers = 0, state IDLE, rsp_valid = 0, rsp_result/rsp_carry/rsp_ip = 0.
- Reset asserted mid-operation aborts it; no writeback occurs.
- States:
  - IDLE: req_ready = 1 (combinational from state).
  - CALC: req_ready = 0.
  - DONE: req_ready = 0, rsp_valid = 1.
- IDLE, on req_valid sampled high:
  - Latch A = reg[req_sel].
  - Latch B: INC = 1; DEC = all ones; ADDD = sign-extended req_disp; reserved = 0.
  - Latch op and sel; latch rsp_ip = req_ip + req_len.
  - Slice counter = 0, carry = 0. Go to CALC.
- CALC:
  - Each cycle adds slice [cnt*SLICE +: SLICE] of A and B plus carry through the slice adder.
  - Stores the sum slice into the result register and updates carry.
  - After slice WIDTH/SLICE-1 completes, go to DONE.
  - rsp_valid is first high in the cycle WIDTH/SLICE+1 cycles after the accepting cycle: 5 cycles for the defaults.
- DONE:
  - rsp_valid = 1; rsp_result, rsp_carry and rsp_ip are stable until the handshake.
  - On rsp_ready: INC/DEC write rsp_result to reg[sel]; ADDD and reserved write nothing. Go to IDLE.
  - A new request can be accepted in the cycle after the handshake.
- Arithmetic wraps modulo 2^WIDTH. INC of all ones gives 0 with carry 1; DEC of 0 gives all ones with carry 0. No flags are produced (INC/DEC IX/IY leave F untouched).
- Register loads:
  - A load is applied only when the state is IDLE and req_valid is low.
  - A load in IDLE with req_valid high is dropped; the request wins.
  - Loads in CALC or DONE are dropped.
- req_sel >= NUM_REGS: A reads as 0 and writeback is suppressed.
- Signals not named in a state (req_disp etc.) are ignored outside IDLE.

Decomposition:
- Package z80_index_arith_pkg:
  - op enum (OP_INC, OP_DEC, OP_ADDD, OP_RSVD).
  - state enum (ST_IDLE, ST_CALC, ST_DONE).
  - Default width constants.
- Sub-module z80_slice_adder: combinational SLICE-bit adder with carry in and carry out, instantiated once.

Test Plan:
- INC of IX:
  - Stimulus: after reset, load reg0 = 16'h12FF; request INC sel0, req_ip = 16'h0100, req_len = 2.
  - Required: rsp_valid 5 cycles after accept; rsp_result = 16'h1300, rsp_ip = 16'h0102.
  - After rsp_ready: regs_out reg0 = 16'h1300, reg1 unchanged.
- DEC of IY wrap:
  - Stimulus: reg1 = 16'h0000; request DEC sel1.
  - Required: rsp_result = 16'hFFFF, rsp_carry = 0; reg1 = 16'hFFFF after the handshake.
- ADDD with negative displacement:
  - Stimulus: reg0 = 16'h8000; request ADDD, req_disp = 8'h80.
  - Required: rsp_result = 16'h7F80, rsp_carry = 1; reg0 stays 16'h8000.
- IP wrap:
  - Stimulus: req_ip = 16'hFFFF, req_len = 2.
  - Required: rsp_ip = 16'h0001.
- Backpressure and dropped load:
  - Stimulus: hold rsp_ready = 0 for 3 cycles, and pulse ld_valid to sel0 during DONE.
  - Required: outputs stay stable, req_ready = 0, the load is ignored; writeback occurs only on the rsp_ready cycle.
- Reset mid-operation:
  - Stimulus: deassert reset_n during CALC of an INC on reg0 = 16'h0005.
  - Required: all registers = 0, rsp_valid = 0, req_ready = 1 after reset release; no writeback.
